// File: rtl/tlc_multi_if.sv
// Host-side bundle for the tlc_multi traffic controller: demand inputs, soft reset and light/status outputs.
// Preemption signals exist only when TLC_PREEMPT_EN is defined.
interface tlc_multi_if #(
  parameter int N_DIR   = 2,
  parameter int TIMER_W = 4
);
  localparam int DIR_W = $clog2(N_DIR);

  logic                 click_rst;
  logic [N_DIR-1:0]     car;
  logic [N_DIR-1:0]     ped_req;
  logic [2*N_DIR-1:0]   light;
  logic [N_DIR-1:0]     ped_walk;
  logic [TIMER_W-1:0]   timer_out;
  logic [1:0]           state;
  logic [DIR_W-1:0]     cur_dir;
`ifdef TLC_PREEMPT_EN
  logic                 preempt;
  logic [DIR_W-1:0]     preempt_dir;

  modport master (
    output click_rst, car, ped_req, preempt, preempt_dir,
    input  light, ped_walk, timer_out, state, cur_dir
  );
  modport slave (
    input  click_rst, car, ped_req, preempt, preempt_dir,
    output light, ped_walk, timer_out, state, cur_dir
  );
`else
  modport master (
    output click_rst, car, ped_req,
    input  light, ped_walk, timer_out, state, cur_dir
  );
  modport slave (
    input  click_rst, car, ped_req,
    output light, ped_walk, timer_out, state, cur_dir
  );
`endif
endinterface

// File: rtl/tlc_multi.sv
// N-approach round-robin traffic light controller with built-in tick divider and phase timer.
// Define TLC_PREEMPT_EN to add emergency preemption (preempt / preempt_dir on the interface).
module tlc_multi #(
  parameter int N_DIR    = 2,
  parameter int TIMER_W  = 4,
  parameter int TICK_DIV = 100000000,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tlc_multi_if.slave bus
);
  localparam int DIR_W = $clog2(N_DIR);
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T);
  localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T);
  localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T);

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [DIR_W-1:0]     cur_dir_q, next_dir_q;
  logic [N_DIR-1:0]     car_q, ped_q, ped_walk_q;
  logic [N_DIR-1:0]     demand, green_mask;
  logic [2*N_DIR-1:0]   light_d;
  logic                 tick, decide, found;
  logic [DIR_W-1:0]     scan_dir, grant_dir;
  logic [DIR_W:0]       idx;
  logic                 pre_on, pre_cut, pre_hold;
  logic [DIR_W-1:0]     pre_dir;

`ifdef TLC_PREEMPT_EN
  assign pre_on  = bus.preempt;
  assign pre_dir = bus.preempt_dir;
`else
  assign pre_on  = 1'b0;
  assign pre_dir = '0;
`endif

  assign tick     = (cnt_q == TICK_LAST);
  assign decide   = tick && (timer_q <= TIMER_ONE);
  assign demand   = car_q | ped_q;
  assign pre_cut  = pre_on && (state_q == S_GREEN) && (cur_dir_q != pre_dir);
  assign pre_hold = pre_on && (state_q == S_GREEN) && (cur_dir_q == pre_dir);
  // An active preempt overrides the round-robin pointer when granting green.
  assign grant_dir = pre_on ? pre_dir : next_dir_q;

  // Round-robin scan for the first other approach with demand, starting after cur_dir.
  always_comb begin
    found    = 1'b0;
    scan_dir = cur_dir_q;
    idx      = '0;
    for (int k = 1; k < N_DIR; k++) begin
      idx = {1'b0, cur_dir_q} + (DIR_W+1)'(k);
      if (idx >= (DIR_W+1)'(N_DIR)) idx = idx - (DIR_W+1)'(N_DIR);
      if (!found && demand[idx[DIR_W-1:0]]) begin
        found    = 1'b1;
        scan_dir = idx[DIR_W-1:0];
      end
    end
  end

  always_comb begin
    green_mask = '0;
    if (state_q == S_GREEN) green_mask[cur_dir_q] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             state_q <= S_ALLRED;
    else if (bus.click_rst) state_q <= S_ALLRED;
    else                    state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (pre_cut) begin
      state_d = S_YELLOW;
    end else if (decide) begin
      case (state_q)
        S_ALLRED: state_d = S_GREEN;
        S_GREEN:  if (found && !pre_hold) state_d = S_YELLOW;
        S_YELLOW: state_d = S_ALLRED;
        default:  state_d = S_ALLRED;
      endcase
    end
  end

  // Tick divider, phase timer, direction pointers, request latches and walk signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      timer_q    <= ALLRED_LD;
      cur_dir_q  <= '0;
      next_dir_q <= '0;
      car_q      <= '0;
      ped_q      <= '0;
      ped_walk_q <= '0;
    end else if (bus.click_rst) begin
      cnt_q      <= '0;
      timer_q    <= ALLRED_LD;
      cur_dir_q  <= '0;
      next_dir_q <= '0;
      car_q      <= '0;
      ped_q      <= '0;
      ped_walk_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      car_q <= car_q | (bus.car & ~green_mask);
      ped_q <= ped_q | bus.ped_req;
      if (pre_cut) begin
        next_dir_q <= pre_dir;
        timer_q    <= YELLOW_LD;
        ped_walk_q <= '0;
      end else if (tick && !decide) begin
        timer_q <= timer_q - TIMER_ONE;
      end else if (decide) begin
        case (state_q)
          S_ALLRED: begin
            // Later bit writes win, so entering green clears the latch over a same-cycle set.
            cur_dir_q             <= grant_dir;
            timer_q               <= GREEN_LD;
            ped_walk_q            <= '0;
            ped_walk_q[grant_dir] <= ped_q[grant_dir];
            car_q[grant_dir]      <= 1'b0;
            ped_q[grant_dir]      <= 1'b0;
          end
          S_GREEN: begin
            if (found && !pre_hold) begin
              next_dir_q <= scan_dir;
              timer_q    <= YELLOW_LD;
              ped_walk_q <= '0;
            end
          end
          S_YELLOW: timer_q <= ALLRED_LD;
          default:  timer_q <= ALLRED_LD;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    light_d = '0;
    case (state_q)
      S_GREEN:  light_d[{cur_dir_q, 1'b0} +: 2] = 2'b10;
      S_YELLOW: light_d[{cur_dir_q, 1'b0} +: 2] = 2'b01;
      default:  light_d = '0;
    endcase
  end

  assign bus.light     = light_d;
  assign bus.ped_walk  = ped_walk_q;
  assign bus.timer_out = timer_q;
  assign bus.state     = state_q;
  assign bus.cur_dir   = cur_dir_q;

endmodule

// File: tb/tb_tlc_multi.sv
// Directed, table-driven bench for tlc_multi: a 2-approach and a 4-approach instance with TICK_DIV=4.
module tb_tlc_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tlc_multi_if #(.N_DIR(2), .TIMER_W(4)) bus2 ();
  tlc_multi_if #(.N_DIR(4), .TIMER_W(4)) bus4 ();

  tlc_multi #(.N_DIR(2), .TIMER_W(4), .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  tlc_multi #(.N_DIR(4), .TIMER_W(4), .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1))
    u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    int         clks;
    logic       click;
    logic [1:0] car;
    logic [1:0] ped;
    logic [3:0] light;
    logic [1:0] st;
    logic [3:0] tmr;
    logic       cur;
    logic [1:0] walk;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [3:0] l, input logic [1:0] s,
                      input logic [3:0] t, input logic c, input logic [1:0] w);
    check({tag, " light"}, 32'(bus2.light), 32'(l));
    check({tag, " state"}, 32'(bus2.state), 32'(s));
    check({tag, " timer"}, 32'(bus2.timer_out), 32'(t));
    check({tag, " cur_dir"}, 32'(bus2.cur_dir), 32'(c));
    check({tag, " ped_walk"}, 32'(bus2.ped_walk), 32'(w));
  endtask

  task automatic chk4(input string tag, input logic [7:0] l, input logic [1:0] s,
                      input logic [3:0] t, input logic [1:0] c);
    check({tag, " light4"}, 32'(bus4.light), 32'(l));
    check({tag, " state4"}, 32'(bus4.state), 32'(s));
    check({tag, " timer4"}, 32'(bus4.timer_out), 32'(t));
    check({tag, " cur_dir4"}, 32'(bus4.cur_dir), 32'(c));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {clks, click, car, ped, light, state, timer, cur_dir, ped_walk}; edge count t noted per row
    tbl[0]  = '{3,   1'b0, 2'b00, 2'b00, 4'b0000, 2'd0, 4'd1, 1'b0, 2'b00}; // t3
    tbl[1]  = '{1,   1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b00}; // t4 first green
    tbl[2]  = '{5,   1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd4, 1'b0, 2'b00}; // t9
    tbl[3]  = '{1,   1'b0, 2'b10, 2'b00, 4'b0010, 2'd1, 4'd4, 1'b0, 2'b00}; // t10 car[1]
    tbl[4]  = '{13,  1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd1, 1'b0, 2'b00}; // t23
    tbl[5]  = '{1,   1'b0, 2'b00, 2'b00, 4'b0001, 2'd2, 4'd2, 1'b0, 2'b00}; // t24 yellow
    tbl[6]  = '{8,   1'b0, 2'b00, 2'b00, 4'b0000, 2'd0, 4'd1, 1'b0, 2'b00}; // t32 all-red
    tbl[7]  = '{4,   1'b0, 2'b00, 2'b00, 4'b1000, 2'd1, 4'd5, 1'b1, 2'b00}; // t36 dir1 green
    tbl[8]  = '{1,   1'b0, 2'b00, 2'b01, 4'b1000, 2'd1, 4'd5, 1'b1, 2'b00}; // t37 ped[0]
    tbl[9]  = '{19,  1'b0, 2'b00, 2'b00, 4'b0100, 2'd2, 4'd2, 1'b1, 2'b00}; // t56
    tbl[10] = '{12,  1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b01}; // t68 walk on
    tbl[11] = '{2,   1'b0, 2'b00, 2'b01, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b01}; // t70 second ped[0]
    tbl[12] = '{1,   1'b0, 2'b10, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b01}; // t71 car[1]
    tbl[13] = '{16,  1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd1, 1'b0, 2'b01}; // t87
    tbl[14] = '{1,   1'b0, 2'b00, 2'b00, 4'b0001, 2'd2, 4'd2, 1'b0, 2'b00}; // t88 walk off
    tbl[15] = '{12,  1'b0, 2'b00, 2'b00, 4'b1000, 2'd1, 4'd5, 1'b1, 2'b00}; // t100
    tbl[16] = '{20,  1'b0, 2'b00, 2'b00, 4'b0100, 2'd2, 4'd2, 1'b1, 2'b00}; // t120
    tbl[17] = '{12,  1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b01}; // t132 latched ped served
    tbl[18] = '{200, 1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd1, 1'b0, 2'b01}; // t332 hold
    tbl[19] = '{1,   1'b1, 2'b00, 2'b00, 4'b0000, 2'd0, 4'd1, 1'b0, 2'b00}; // t333 soft reset
    tbl[20] = '{4,   1'b0, 2'b00, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b00}; // t337
    tbl[21] = '{1,   1'b0, 2'b01, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b00}; // t338 car on green dir
    tbl[22] = '{1,   1'b0, 2'b10, 2'b00, 4'b0010, 2'd1, 4'd5, 1'b0, 2'b00}; // t339
    tbl[23] = '{30,  1'b0, 2'b00, 2'b00, 4'b1000, 2'd1, 4'd5, 1'b1, 2'b00}; // t369
    tbl[24] = '{31,  1'b0, 2'b00, 2'b00, 4'b1000, 2'd1, 4'd1, 1'b1, 2'b00}; // t400 hold

    bus2.click_rst = 1'b0; bus2.car = '0; bus2.ped_req = '0;
    bus4.click_rst = 1'b0; bus4.car = '0; bus4.ped_req = '0;
`ifdef TLC_PREEMPT_EN
    bus2.preempt = 1'b0; bus2.preempt_dir = '0;
    bus4.preempt = 1'b0; bus4.preempt_dir = '0;
`endif

    #12 rst_n = 1'b1;
    #1;
    chk2("reset", 4'b0000, 2'd0, 4'd1, 1'b0, 2'b00);

    for (int i = 0; i < 25; i++) begin
      bus2.click_rst = tbl[i].click;
      bus2.car       = tbl[i].car;
      bus2.ped_req   = tbl[i].ped;
      step(1);
      bus2.click_rst = 1'b0;
      bus2.car       = '0;
      bus2.ped_req   = '0;
      if (tbl[i].clks > 1) step(tbl[i].clks - 1);
      chk2($sformatf("v%0d", i), tbl[i].light, tbl[i].st, tbl[i].tmr, tbl[i].cur, tbl[i].walk);
    end

    // Async reset mid-yellow drops outputs at once and discards a pending car request.
    bus2.car = 2'b01; step(1); bus2.car = '0;
    step(4);
    chk2("pre_rst_yellow", 4'b0100, 2'd2, 4'd2, 1'b1, 2'b00);
    bus2.car = 2'b10; step(1); bus2.car = '0;
    #2 rst_n = 1'b0;
    #1;
    chk2("async_rst", 4'b0000, 2'd0, 4'd1, 1'b0, 2'b00);
    #1 rst_n = 1'b1;
    step(4);
    chk2("post_rst_green", 4'b0010, 2'd1, 4'd5, 1'b0, 2'b00);
    step(26);
    chk2("lost_request", 4'b0010, 2'd1, 4'd1, 1'b0, 2'b00);

    // Four approaches: requests on 3 then 1 are served 1 first, then 3, which then holds.
    bus4.click_rst = 1'b1; step(1); bus4.click_rst = 1'b0;
    chk4("n4_click", 8'h00, 2'd0, 4'd1, 2'd0);
    step(4);
    chk4("n4_green0", 8'b0000_0010, 2'd1, 4'd5, 2'd0);
    bus4.car = 4'b1000; step(1);
    bus4.car = 4'b0010; step(1);
    bus4.car = '0;
    step(18);
    chk4("n4_yellow0", 8'b0000_0001, 2'd2, 4'd2, 2'd0);
    step(12);
    chk4("n4_green1", 8'b0000_1000, 2'd1, 4'd5, 2'd1);
    step(20);
    chk4("n4_yellow1", 8'b0000_0100, 2'd2, 4'd2, 2'd1);
    step(12);
    chk4("n4_green3", 8'b1000_0000, 2'd1, 4'd5, 2'd3);
    step(32);
    chk4("n4_hold3", 8'b1000_0000, 2'd1, 4'd1, 2'd3);

`ifdef TLC_PREEMPT_EN
    bus2.click_rst = 1'b1; step(1); bus2.click_rst = 1'b0;
    step(8);
    chk2("pre_base", 4'b0010, 2'd1, 4'd4, 1'b0, 2'b00);
    bus2.preempt = 1'b1; bus2.preempt_dir = 1'b1;
    step(1);
    chk2("pre_cut", 4'b0001, 2'd2, 4'd2, 1'b0, 2'b00);
    step(11);
    chk2("pre_grant", 4'b1000, 2'd1, 4'd5, 1'b1, 2'b00);
    bus2.car = 2'b01; step(1); bus2.car = '0;
    step(39);
    chk2("pre_hold", 4'b1000, 2'd1, 4'd1, 1'b1, 2'b00);
    bus2.preempt = 1'b0;
    step(4);
    chk2("pre_release", 4'b0100, 2'd2, 4'd2, 1'b1, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
